// File: rtl/bip_pkg.sv
// Constants and state encoding shared by the BIP program loader and CPU decode.
package bip_pkg;

    localparam int unsigned RAM_WIDTH = 16;
    localparam int unsigned ADDR_BITS = 11;
    localparam int unsigned WC_BITS   = ADDR_BITS + 1;
    localparam int unsigned BYTE_W    = 8;

    localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h52;
    localparam logic [BYTE_W-1:0] CMD_STOP = 8'h53;
    localparam logic [BYTE_W-1:0] ACK_BYTE = 8'h4B;

    localparam logic [4:0]           HLT_OPCODE = 5'b00000;
    localparam logic [ADDR_BITS-1:0] ADDR_LAST  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_HI,
        ST_RX_LO,
        ST_WRITE,
        ST_ACK,
        ST_RUN
    } loader_state_t;

    // A load ends on the all-zero word: HLT opcode with a zero operand.
    function automatic logic is_halt_word(input logic [RAM_WIDTH-1:0] w);
        return (w[RAM_WIDTH-1 -: 5] == HLT_OPCODE) && (w[RAM_WIDTH-6:0] == '0);
    endfunction

endpackage

// File: rtl/program_loader.sv
// UART-driven program loader that also arbitrates the program memory port
// between the loader (IDLE..ACK) and the CPU fetch path (RUN).
module program_loader
    import bip_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_done,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [BYTE_W-1:0]    tx_data,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 cpu_reset,
    output logic [WC_BITS-1:0]   word_count
);

    loader_state_t        state;
    logic [ADDR_BITS-1:0] ptr;

    // Port ownership: CPU fetch address only while running, loader pointer otherwise.
    assign mem_addr = (state == ST_RUN) ? cpu_addr : ptr;

    // Loader FSM with registered outputs; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            word_count <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= ACK_BYTE;
            cpu_reset  <= 1'b1;
        end else begin
            mem_we   <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cpu_reset <= 1'b1;
                    if (rx_done) begin
                        if (rx_data == CMD_LOAD) begin
                            ptr        <= '0;
                            word_count <= '0;
                            state      <= ST_RX_HI;
                        end else if (rx_data == CMD_RUN) begin
                            cpu_reset <= 1'b0;
                            state     <= ST_RUN;
                        end
                    end
                end
                ST_RX_HI: begin
                    if (rx_done) begin
                        mem_wdata[RAM_WIDTH-1:BYTE_W] <= rx_data;
                        state                         <= ST_RX_LO;
                    end
                end
                ST_RX_LO: begin
                    if (rx_done) begin
                        mem_wdata[BYTE_W-1:0] <= rx_data;
                        mem_we                <= 1'b1;
                        state                 <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The pointer saturates at the last word so a full memory never wraps.
                    word_count <= word_count + WC_BITS'(1);
                    if (ptr != ADDR_LAST) begin
                        ptr <= ptr + ADDR_BITS'(1);
                    end
                    if (is_halt_word(mem_wdata) || (ptr == ADDR_LAST)) begin
                        state <= ST_ACK;
                    end else begin
                        state <= ST_RX_HI;
                    end
                end
                ST_ACK: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= ACK_BYTE;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cpu_reset <= 1'b0;
                    if (rx_done && (rx_data == CMD_STOP)) begin
                        cpu_reset <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go to a scoreboard
// queue as bytes are sent and are popped by a monitor on every mem_we pulse.
module tb_program_loader;
    import bip_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [BYTE_W-1:0]    rx_data;
    logic                 rx_done;
    logic                 tx_busy;
    logic                 tx_start;
    logic [BYTE_W-1:0]    tx_data;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0] mem_wdata;
    logic                 mem_we;
    logic                 cpu_reset;
    logic [WC_BITS-1:0]   word_count;

    int compared   = 0;
    int mismatched = 0;
    int tx_cnt     = 0;
    int exp_tx     = 0;
    logic [31:0] sb[$];
    logic [ADDR_BITS-1:0] last_addr = '0;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .cpu_addr   (cpu_addr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_reset  (cpu_reset),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest expected {addr,data}; any unexpected write underflows.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(sb.size()), 32'd1);
            end else begin
                chk("write", 32'({mem_addr, mem_wdata}), sb.pop_front());
            end
            last_addr = mem_addr;
        end
        if (tx_start === 1'b1) tx_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // High byte, low byte, then one quiet cycle for the WRITE state.
    task automatic send_word(input logic [ADDR_BITS-1:0] a, input logic [15:0] w);
        sb.push_back(32'({a, w}));
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        tick();
    endtask

    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        exp_tx++;
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
        chk({tag, "_ack_byte"}, 32'(tx_data), 32'h4B);
        tick();
        chk({tag, "_cpu_release"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_tx_count"}, 32'(tx_cnt), 32'(exp_tx));
    endtask

    initial begin
        int held;
        reset    = 1'b1;
        rx_data  = '0;
        rx_done  = 1'b0;
        tx_busy  = 1'b0;
        cpu_addr = '0;
        repeat (3) tick();

        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h4B);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Three-word load ending on HLT.
        send_byte(8'h41);
        chk("idle_ignore", 32'(cpu_reset), 32'd1);
        send_byte(8'h4C);
        sb.push_back(32'({11'h000, 16'h1234}));
        send_byte(8'h12);
        send_byte(8'h34);
        chk("we_latency", 32'(mem_we), 32'd1);
        tick();
        send_word(11'h001, 16'hABCD);
        send_word(11'h002, 16'h0000);
        wait_ack("load3");
        chk("load3_word_count", 32'(word_count), 32'd3);
        cpu_addr = 11'h123;
        tick();
        chk("load3_cpu_addr", 32'(mem_addr), 32'h123);
        chk("load3_sb_empty", 32'(sb.size()), 32'd0);

        // Stop, run without load, ignore other bytes, stop again.
        send_byte(8'h53);
        chk("stop_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("stop_mem_addr", 32'(mem_addr), 32'd3);
        send_byte(8'h52);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_mem_addr", 32'(mem_addr), 32'h123);
        send_byte(8'h41);
        tick();
        chk("run_ignore", 32'(cpu_reset), 32'd0);
        send_byte(8'h53);
        chk("stop2_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("stop2_mem_addr", 32'(mem_addr), 32'd3);

        // Reset after the high byte abandons the partial word.
        send_byte(8'h4C);
        send_byte(8'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("midrst_still_idle", 32'(mem_we), 32'd0);
        send_byte(8'h4C);
        send_word(11'h000, 16'h0001);
        send_word(11'h001, 16'h0000);
        wait_ack("reload");
        chk("reload_word_count", 32'(word_count), 32'd2);

        // ACK held off by a busy transmitter.
        send_byte(8'h53);
        send_byte(8'h4C);
        send_word(11'h000, 16'hBEEF);
        tx_busy = 1'b1;
        send_word(11'h001, 16'h0000);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_start === 1'b1) held++;
            tick();
        end
        chk("busy_holdoff", 32'(held), 32'd0);
        chk("busy_cpu_held", 32'(cpu_reset), 32'd1);
        tx_busy = 1'b0;
        tick();
        chk("busy_release_pulse", 32'(tx_start), 32'd1);
        wait_ack("busy");
        chk("busy_single_pulse", 32'(tx_start), 32'd0);

        // Full memory: 2048 nonzero words, last write at 0x7FF, no wrap.
        send_byte(8'h53);
        send_byte(8'h4C);
        for (int i = 0; i < 2048; i++) begin
            send_word(ADDR_BITS'(i), 16'(i + 1));
        end
        wait_ack("full");
        chk("full_word_count", 32'(word_count), 32'd2048);
        chk("full_last_addr", 32'(last_addr), 32'h7FF);
        repeat (4) tick();
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        chk("full_tx_count", 32'(tx_cnt), 32'(exp_tx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
